// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state and direction encodings for the counter scheduler
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick, searching from ptr+1 upward mod NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);

  always_comb begin
    any    = 1'b0;
    idx    = '0;
    onehot = '0;
    // k runs to NREQ so the requester at ptr itself is considered last
    for (int k = 1; k <= NREQ; k++) begin
      int pos;
      pos = (int'(ptr) + k) % NREQ;
      if (!any && req[pos]) begin
        any = 1'b1;
        idx = PW'(pos);
      end
    end
    onehot[idx] = any;
  end

endmodule

// File: rtl/counter_op_scheduler.sv
// rtl/counter_op_scheduler.sv - round-robin scheduler applying single up/down steps to a shared counter
module counter_op_scheduler
  import counter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  dir,
  input  logic             clr,
  output logic [NREQ-1:0]  gnt,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, win;
  logic            ldir;
  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic            at_max, at_min, boundary;
  logic [WIDTH-1:0] stepped, step_next;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = ST_GRANT;
      ST_GRANT: state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // Boundary detection drives both the err flag and saturation when WRAP is off
  assign at_max    = (count == {WIDTH{1'b1}});
  assign at_min    = (count == '0);
  assign boundary  = (ldir == DIR_UP) ? at_max : at_min;
  assign stepped   = (ldir == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
  assign step_next = ((WRAP == 0) && boundary) ? count : stepped;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= PW'(NREQ - 1);
      win   <= '0;
      ldir  <= DIR_DN;
      gnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            win  <= pick_idx;
            ldir <= dir[pick_idx];
            gnt  <= pick_onehot;
          end
        end
        ST_GRANT: begin
          done <= 1'b1;
          err  <= boundary & ~clr;
          if (!clr) count <= step_next;
        end
        ST_ACK: begin
          ptr <= win;
          gnt <= '0;
        end
        default: gnt <= '0;
      endcase
      // clear overrides any step landing on the same edge
      if (clr) count <= '0;
    end
  end

endmodule

// File: tb/tb_counter_op_scheduler.sv
// tb/tb_counter_op_scheduler.sv - directed self-checking bench for counter_op_scheduler (wrap and saturate builds)
module tb_counter_op_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] dir = '0;
  logic       clr = 1'b0;

  logic [3:0] gnt, s_gnt;
  logic       done, err, busy, s_done, s_err, s_busy;
  logic [2:0] count, s_count;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  counter_op_scheduler #(.NREQ(4), .WIDTH(3), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .req(req), .dir(dir), .clr(clr),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .count(count)
  );

  counter_op_scheduler #(.NREQ(4), .WIDTH(3), .WRAP(0)) dut_sat (
    .clk(clk), .reset(reset), .req(req), .dir(dir), .clr(clr),
    .gnt(s_gnt), .done(s_done), .err(s_err), .busy(s_busy), .count(s_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input string tag, input logic [3:0] r, input logic [3:0] d,
                       input logic [3:0] eg, input logic [2:0] ec, input logic ee,
                       input logic [2:0] sc, input logic se);
    req = r;
    dir = d;
    tick;
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".done_early"}, 32'(done), 32'd0);
    tick;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".gnt_held"}, 32'(gnt), 32'(eg));
    chk({tag, ".count"}, 32'(count), 32'(ec));
    chk({tag, ".err"}, 32'(err), 32'(ee));
    chk({tag, ".s_count"}, 32'(s_count), 32'(sc));
    chk({tag, ".s_err"}, 32'(s_err), 32'(se));
    req = '0;
    tick;
    chk({tag, ".done_drop"}, 32'(done), 32'd0);
    chk({tag, ".gnt_clear"}, 32'(gnt), 32'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req = '0;
    clr = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.s_count", 32'(s_count), 32'd0);
    do_reset;

    // single request from requester 0
    serve("t1", 4'b0001, 4'b0001, 4'b0001, 3'd1, 1'b0, 3'd1, 1'b0);

    // fairness with all four requesting up
    do_reset;
    for (int i = 0; i < 8; i++) begin
      serve($sformatf("t2.%0d", i), 4'b1111, 4'b1111, 4'(1 << (i % 4)),
            3'((i + 1) % 8), (i == 7), (i == 7) ? 3'd7 : 3'(i + 1), (i == 7));
    end

    // clear, then down step at zero: wrap -> 7, saturate stays 0
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("t3.clr_count", 32'(count), 32'd0);
    chk("t3.clr_s_count", 32'(s_count), 32'd0);
    serve("t3.dn", 4'b0001, 4'b0000, 4'b0001, 3'd7, 1'b1, 3'd0, 1'b1);

    // clr during GRANT at count 5
    do_reset;
    for (int i = 0; i < 5; i++)
      serve($sformatf("t4.up%0d", i), 4'b0001, 4'b0001, 4'b0001,
            3'(i + 1), 1'b0, 3'(i + 1), 1'b0);
    req = 4'b0001;
    dir = 4'b0001;
    tick;
    chk("t4.gnt", 32'(gnt), 32'b0001);
    clr = 1'b1;
    tick;
    clr = 1'b0;
    req = '0;
    chk("t4.done", 32'(done), 32'd1);
    chk("t4.err", 32'(err), 32'd0);
    chk("t4.count", 32'(count), 32'd0);
    chk("t4.s_count", 32'(s_count), 32'd0);
    tick;

    // reset asserted during GRANT at count 3
    for (int i = 0; i < 3; i++)
      serve($sformatf("t5.up%0d", i), 4'b0001, 4'b0001, 4'b0001,
            3'(i + 1), 1'b0, 3'(i + 1), 1'b0);
    req = 4'b0010;
    dir = 4'b0010;
    tick;
    chk("t5.gnt", 32'(gnt), 32'b0010);
    reset = 1'b1;
    #1;
    chk("t5.rst_gnt", 32'(gnt), 32'd0);
    chk("t5.rst_count", 32'(count), 32'd0);
    chk("t5.rst_busy", 32'(busy), 32'd0);
    tick;
    chk("t5.rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    serve("t5.after", 4'b1111, 4'b1111, 4'b0001, 3'd1, 1'b0, 3'd1, 1'b0);

    // requester 2 withdraws and flips dir during GRANT
    req = 4'b0100;
    dir = 4'b0100;
    tick;
    chk("t6.gnt", 32'(gnt), 32'b0100);
    req = '0;
    dir = '0;
    tick;
    chk("t6.done", 32'(done), 32'd1);
    chk("t6.count", 32'(count), 32'd2);
    chk("t6.err", 32'(err), 32'd0);
    tick;
    chk("t6.done_drop", 32'(done), 32'd0);
    serve("t6.next", 4'b0101, 4'b0101, 4'b0001, 3'd3, 1'b0, 3'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
